vga_square_plotter: RTL and testbench

VGA_SQUARE_PLOTTER -- requirements
Module: vga_square_plotter

---
 rtl/vga_square_plotter.sv | 191 +++++++++++++++++++
 tb/tb_vga_square_plotter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_square_plotter.sv
// Draws a 2**SIDE_LOG2 square or clears the SCR_W x SCR_H frame buffer, one pixel per clock.
// Define SQUARE_CLIP_EN to suppress writes for square pixels that land off-screen.
module vga_square_plotter #(
  parameter int SIDE_LOG2 = 2,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] pos_in,
  input  logic [2:0] colour_in,
  input  logic       store_pos,
  input  logic       clear_scr,
  input  logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);
  localparam int CW = 2 * SIDE_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);

  logic [1:0]    state_q, state_d;
  logic          store_prev_q, plot_prev_q, clear_prev_q;
  logic [6:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          ptr_q, ptr_d;
  logic [6:0]    org_x_q, org_x_d, org_y_q, org_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d;

  logic          store_edge, plot_edge, clear_edge;
  logic [CW-1:0] pix;
  logic [6:0]    base_x, base_y;
  logic [7:0]    draw_x;
  logic [6:0]    draw_y;
  logic          draw_vis;

  assign store_edge = store_pos & ~store_prev_q;
  assign plot_edge  = plot & ~plot_prev_q;
  assign clear_edge = clear_scr & ~clear_prev_q;

  // The pixel issued next: index 0 from the stored position on entry, else the successor of cnt.
  assign pix    = (state_q == S_DRAW) ? cnt_q + CW'(1) : '0;
  assign base_x = (state_q == S_DRAW) ? org_x_q : pos_x_q;
  assign base_y = (state_q == S_DRAW) ? org_y_q : pos_y_q;
  assign draw_x = {1'b0, base_x} + 8'(pix[SIDE_LOG2-1:0]);
  assign draw_y = base_y + 7'(pix[CW-1:SIDE_LOG2]);

`ifdef SQUARE_CLIP_EN
  localparam logic [7:0] X_LIM = 8'(SCR_W);
  localparam logic [7:0] Y_LIM = 8'(SCR_H);
  logic [7:0] draw_y_full;
  assign draw_y_full = {1'b0, base_y} + 8'(pix[CW-1:SIDE_LOG2]);
  assign draw_vis    = (draw_x < X_LIM) && (draw_y_full < Y_LIM);
`else
  assign draw_vis = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    ptr_d    = ptr_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (store_edge) begin
      if (!ptr_q) pos_x_d = pos_in;
      else        pos_y_d = pos_in;
      ptr_d = ~ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_edge) begin
          state_d  = S_CLEAR;
          x_d      = '0;
          y_d      = '0;
          colour_d = '0;
          we_d     = 1'b1;
          busy_d   = 1'b1;
        end else if (plot_edge) begin
          state_d  = S_DRAW;
          org_x_d  = pos_x_q;
          org_y_d  = pos_y_q;
          cnt_d    = '0;
          x_d      = draw_x;
          y_d      = draw_y;
          colour_d = colour_in;
          we_d     = draw_vis;
          busy_d   = 1'b1;
        end
      end
      S_DRAW: begin
        if (cnt_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = pix;
          x_d   = draw_x;
          y_d   = draw_y;
          we_d  = draw_vis;
        end
      end
      S_CLEAR: begin
        // x_q/y_q double as the raster counters since they already hold the last pixel issued.
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d  = '0;
            y_d  = y_q + 7'd1;
            we_d = 1'b1;
          end
        end else begin
          x_d  = x_q + 8'd1;
          we_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      // History follows the input levels so a request held high across reset is not a new edge.
      store_prev_q <= store_pos;
      plot_prev_q  <= plot;
      clear_prev_q <= clear_scr;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      ptr_q        <= 1'b0;
      org_x_q      <= '0;
      org_y_q      <= '0;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_prev_q <= store_pos;
      plot_prev_q  <= plot;
      clear_prev_q <= clear_scr;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      ptr_q        <= ptr_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign writeEn = we_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_vga_square_plotter.sv
// Self-checking bench for vga_square_plotter: table vectors, random squares, clear and reset corners.
// Honours SQUARE_CLIP_EN so the same bench checks either build.
module tb_vga_square_plotter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] pos_in = '0;
  logic [2:0] colour_in = '0;
  logic       store_pos = 1'b0;
  logic       clear_scr = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy, done;

  vga_square_plotter dut (
    .clock(clock), .reset(reset), .pos_in(pos_in), .colour_in(colour_in),
    .store_pos(store_pos), .clear_scr(clear_scr), .plot(plot),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       busy;
    logic       done;
  } sample_t;

  typedef struct {
    int px;
    int py;
    int col;
    int exp_writes;
    int exp_last_x;
    int exp_last_y;
  } vec_t;

  int      checks = 0;
  int      failures = 0;
  sample_t cap[$];
  sample_t exp_q[$];
  sample_t wr_q[$];
  vec_t    vecs[4];
  int      m_x, m_y;
  bit      m_ptr;
  int      poke_a, poke_b;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string nm, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, actual, expected);
    end
  endtask

  // Position registers alternate X, Y, X, ... from reset.
  function automatic void modelStore(input int v);
    if (!m_ptr) m_x = v;
    else        m_y = v;
    m_ptr = !m_ptr;
  endfunction

  // Expected write list: 4x4 square in row-major order, x 8-bit, y modulo 128 unless clipped.
  function automatic void modelSquare(input int px, input int py, input int col);
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int xx = px + c;
        int yy = py + r;
`ifdef SQUARE_CLIP_EN
        if (xx >= 160 || yy >= 120) continue;
`endif
        exp_q.push_back(sample_t'{1'b1, 8'(xx), 7'(yy % 128), 3'(col), 1'b1, 1'b0});
      end
    end
  endfunction

  task automatic storePos(input int v);
    pos_in = 7'(v);
    store_pos = 1'b1;
    tick();
    store_pos = 1'b0;
    tick();
    modelStore(v);
  endtask

  // Raises the requested inputs, then records outputs every cycle until done or the budget expires.
  // poke_kind 1 toggles plot mid-operation; poke_kind 2 stores poke_a/poke_b while busy.
  task automatic applyStimulus(input bit do_plot, input bit do_clear, input int col,
                               input int poke_at, input int poke_kind, input int max_cycles);
    cap.delete();
    colour_in = 3'(col);
    if (do_plot)  plot = 1'b1;
    if (do_clear) clear_scr = 1'b1;
    for (int k = 0; k < max_cycles; k++) begin
      tick();
      cap.push_back(sample_t'{writeEn, x, y, colour, busy, done});
      if (poke_kind == 1) begin
        if (k == poke_at || k == poke_at + 4) plot = 1'b0;
        if (k == poke_at + 2) plot = 1'b1;
      end
      if (poke_kind == 2) begin
        if (k == poke_at)     begin pos_in = 7'(poke_a); store_pos = 1'b1; modelStore(poke_a); end
        if (k == poke_at + 1) store_pos = 1'b0;
        if (k == poke_at + 2) begin pos_in = 7'(poke_b); store_pos = 1'b1; modelStore(poke_b); end
        if (k == poke_at + 3) store_pos = 1'b0;
      end
      if (done) break;
    end
  endtask

  task automatic checkDraw(input string nm, input int px, input int py, input int col);
    int bad = 0;
    int bad_busy = 0;
    modelSquare(px, py, col);
    wr_q.delete();
    foreach (cap[i]) if (cap[i].we) wr_q.push_back(cap[i]);
    checkOutput({nm, "_writes"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i >= wr_q.size()) bad++;
      else if (wr_q[i].x !== exp_q[i].x || wr_q[i].y !== exp_q[i].y || wr_q[i].c !== exp_q[i].c) bad++;
    end
    checkOutput({nm, "_pixel_errors"}, bad, 0);
    checkOutput({nm, "_done_cycle"}, cap.size() - 1, 16);
    checkOutput({nm, "_done_seen"}, int'(cap[$].done), 1);
    checkOutput({nm, "_we_at_done"}, int'(cap[$].we), 0);
    checkOutput({nm, "_busy_at_done"}, int'(cap[$].busy), 0);
    for (int i = 0; i < cap.size() - 1; i++) if (cap[i].busy !== 1'b1 || cap[i].done !== 1'b0) bad_busy++;
    checkOutput({nm, "_busy_errors"}, bad_busy, 0);
  endtask

  task automatic checkClear(input string nm);
    int bad = 0;
    int n_we = 0;
    for (int i = 0; i < cap.size() - 1; i++) begin
      if (cap[i].we === 1'b1) n_we++;
      if (cap[i].we !== 1'b1 || cap[i].x !== 8'(i % 160) || cap[i].y !== 7'(i / 160) ||
          cap[i].c !== 3'd0 || cap[i].busy !== 1'b1) bad++;
    end
    checkOutput({nm, "_writes"}, n_we, 19200);
    checkOutput({nm, "_raster_errors"}, bad, 0);
    checkOutput({nm, "_done_cycle"}, cap.size() - 1, 19200);
    checkOutput({nm, "_done_seen"}, int'(cap[$].done), 1);
    checkOutput({nm, "_first_xy"}, int'({cap[0].x, 1'b0, cap[0].y}), 0);
    if (cap.size() > 19199)
      checkOutput({nm, "_last_xy"}, int'({cap[19199].x, 1'b0, cap[19199].y}), (159 << 8) | 119);
    else
      checkOutput({nm, "_last_xy"}, -1, (159 << 8) | 119);
  endtask

  task automatic watchQuiet(input string nm, input int cycles);
    int n_we = 0;
    int n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (writeEn !== 1'b0) n_we++;
      if (done !== 1'b0) n_done++;
    end
    checkOutput({nm, "_writes"}, n_we, 0);
    checkOutput({nm, "_dones"}, n_done, 0);
  endtask

  task automatic checkResetOutputs(input string nm);
    checkOutput({nm, "_x"}, int'(x), 0);
    checkOutput({nm, "_y"}, int'(y), 0);
    checkOutput({nm, "_colour"}, int'(colour), 0);
    checkOutput({nm, "_we"}, int'(writeEn), 0);
    checkOutput({nm, "_busy"}, int'(busy), 0);
    checkOutput({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    vecs[0] = '{10, 20, 5, 16, 13, 23};
    vecs[1] = '{0, 0, 7, 16, 3, 3};
`ifdef SQUARE_CLIP_EN
    vecs[2] = '{127, 118, 3, 8, 130, 119};
    vecs[3] = '{50, 126, 2, 0, -1, -1};
`else
    vecs[2] = '{127, 118, 3, 16, 130, 121};
    vecs[3] = '{50, 126, 2, 16, 53, 1};
`endif
    m_x = 0; m_y = 0; m_ptr = 1'b0;

    repeat (3) tick();
    checkResetOutputs("reset");
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      storePos(vecs[i].px);
      storePos(vecs[i].py);
      applyStimulus(1'b1, 1'b0, vecs[i].col, -1, 0, 40);
      plot = 1'b0;
      tick();
      checkDraw($sformatf("vec%0d", i), m_x, m_y, vecs[i].col);
      checkOutput($sformatf("vec%0d_table_writes", i), wr_q.size(), vecs[i].exp_writes);
      if (vecs[i].exp_writes > 0 && wr_q.size() > 0) begin
        checkOutput($sformatf("vec%0d_last_x", i), int'(wr_q[$].x), vecs[i].exp_last_x);
        checkOutput($sformatf("vec%0d_last_y", i), int'(wr_q[$].y), vecs[i].exp_last_y);
      end
    end

    for (int i = 0; i < 6; i++) begin
      int col = int'($urandom_range(0, 7));
      storePos(int'($urandom_range(0, 127)));
      storePos(int'($urandom_range(0, 127)));
      applyStimulus(1'b1, 1'b0, col, -1, 0, 40);
      plot = 1'b0;
      tick();
      checkDraw($sformatf("rand%0d", i), m_x, m_y, col);
    end

    // New position stored mid-draw must not disturb the square in flight.
    storePos(10);
    storePos(20);
    poke_a = 40; poke_b = 50;
    applyStimulus(1'b1, 1'b0, 6, 3, 2, 40);
    plot = 1'b0;
    tick();
    checkDraw("busy_store_cur", 10, 20, 6);
    applyStimulus(1'b1, 1'b0, 1, -1, 0, 40);
    plot = 1'b0;
    tick();
    checkDraw("busy_store_next", m_x, m_y, 1);
    checkOutput("busy_store_model_x", m_x, 40);

    // Plot held high for 1000 cycles draws exactly one square.
    applyStimulus(1'b1, 1'b0, 4, -1, 0, 40);
    checkDraw("held_plot", m_x, m_y, 4);
    watchQuiet("held_plot_tail", 1000 - cap.size());
    plot = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b1, 5, -1, 0, 19300);
    clear_scr = 1'b0;
    checkClear("clear");
    tick();

    // Simultaneous plot and clear: clear wins; plot re-raised mid-clear is ignored.
    applyStimulus(1'b1, 1'b1, 2, 100, 1, 19300);
    plot = 1'b0;
    clear_scr = 1'b0;
    checkClear("both");
    watchQuiet("both_after", 40);

    // Reset on the 5th draw cycle with plot held high through reset.
    storePos(30);
    storePos(40);
    colour_in = 3'd7;
    plot = 1'b1;
    tick();
    checkOutput("rst_draw_first_we", int'(writeEn), 1);
    repeat (4) tick();
    checkOutput("rst_draw_5th_x", int'(x), 30);
    checkOutput("rst_draw_5th_y", int'(y), 41);
    reset = 1'b1;
    tick();
    checkResetOutputs("rst_mid");
    reset = 1'b0;
    m_x = 0; m_y = 0; m_ptr = 1'b0;
    watchQuiet("rst_after", 30);
    plot = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 3, -1, 0, 40);
    plot = 1'b0;
    tick();
    checkDraw("rst_origin", m_x, m_y, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
